// File: rtl/log2_pkg.sv
// Shared types and helpers for the sequential base-2 logarithm unit.
package log2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StIter,
    StDone
  } state_e;

  // Converts an unsigned fixed-point result with `frac` fraction bits to a real.
  function automatic real fx2real(input logic [63:0] value, input int unsigned frac);
    return real'(value) / (2.0 ** frac);
  endfunction

endpackage

// File: rtl/log2_seq_if.sv
// Argument/result handshake bundle for log2_seq.
interface log2_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) ();

  localparam int unsigned LogW = $clog2(WIDTH) + FRAC;

  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_arg;
  logic             o_valid;
  logic             o_ready;
  logic [LogW-1:0]  o_log;
  logic             o_err;

  modport master (
    output i_valid, i_arg, o_ready,
    input  i_ready, o_valid, o_log, o_err
  );

  modport slave (
    input  i_valid, i_arg, o_ready,
    output i_ready, o_valid, o_log, o_err
  );

endinterface

// File: rtl/log2_msb_detect.sv
// Combinational priority encoder: index of the most significant set bit plus a zero flag.
module log2_msb_detect #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         value_i,
  output logic [$clog2(WIDTH)-1:0] msb_o,
  output logic                     zero_o
);

  always_comb begin
    msb_o  = '0;
    zero_o = (value_i == '0);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value_i[i]) begin
        msb_o = $clog2(WIDTH)'(i);
      end
    end
  end

endmodule

// File: rtl/log2_seq.sv
// Sequential fixed-point log2: leading-one detect for the integer part, then one
// fraction bit per clock by repeated squaring of the normalised mantissa.
module log2_seq
  import log2_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned MANT_W = FRAC + 4
) (
  input  logic        clock,
  input  logic        reset,
  log2_seq_if.slave   bus
);

  localparam int unsigned IntW = $clog2(WIDTH);
  localparam int unsigned Mw1  = MANT_W + 1;
  localparam int unsigned SqW  = 2 * Mw1;
  localparam int unsigned CntW = $clog2(FRAC + 1);

  state_e              state_q;
  logic [WIDTH-1:0]    arg_q;
  logic [MANT_W:0]     mant_q;
  logic [CntW-1:0]     cnt_q;
  logic [FRAC-1:0]     frac_q;
  logic [IntW-1:0]     int_q;
  logic                i_ready_q;
  logic                o_valid_q;
  logic [IntW+FRAC-1:0] o_log_q;
  logic                o_err_q;

  logic [IntW-1:0]        msb;
  logic                   arg_zero;
  logic [IntW-1:0]        shamt;
  logic [WIDTH+Mw1-1:0]   norm_ext;
  logic [MANT_W:0]        mant_norm;
  logic [SqW-1:0]         sq;
  logic                   frac_bit;
  logic [MANT_W:0]        mant_d;
  logic [FRAC:0]          frac_ext;
  logic [FRAC-1:0]        frac_d;
  logic                   unused_bits;

  log2_msb_detect #(
    .WIDTH (WIDTH)
  ) u_msb_detect (
    .value_i (arg_q),
    .msb_o   (msb),
    .zero_o  (arg_zero)
  );

  // Padding with Mw1 zeros covers both WIDTH-1 >= MANT_W and the zero-extended case.
  always_comb begin
    shamt     = IntW'(WIDTH - 1) - msb;
    norm_ext  = {arg_q, {Mw1{1'b0}}} << shamt;
    mant_norm = norm_ext[WIDTH+Mw1-1 -: Mw1];
  end

  // m is 1.MANT_W, so m*m is in [1,4); the top bit decides the next fraction bit.
  always_comb begin
    sq       = SqW'(mant_q) * SqW'(mant_q);
    frac_bit = sq[SqW-1];
    mant_d   = frac_bit ? sq[SqW-1 -: Mw1] : sq[SqW-2 -: Mw1];
    frac_ext = {frac_q, frac_bit};
    frac_d   = frac_ext[FRAC-1:0];
  end

  assign unused_bits = ^{norm_ext[WIDTH-1:0], sq[MANT_W-1:0], frac_ext[FRAC]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      arg_q     <= '0;
      mant_q    <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      int_q     <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_log_q   <= '0;
      o_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            arg_q     <= bus.i_arg;
            i_ready_q <= 1'b0;
            state_q   <= StNorm;
          end
        end
        StNorm: begin
          if (arg_zero) begin
            o_log_q   <= '0;
            o_err_q   <= 1'b1;
            o_valid_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            int_q   <= msb;
            mant_q  <= mant_norm;
            cnt_q   <= CntW'(FRAC - 1);
            frac_q  <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          mant_q <= mant_d;
          frac_q <= frac_d;
          if (cnt_q == '0) begin
            o_log_q   <= {int_q, frac_d};
            o_err_q   <= 1'b0;
            o_valid_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_log   = o_log_q;
  assign bus.o_err   = o_err_q;

endmodule

// File: doc/log2_seq.md
Name: log2_seq

Overview:
- Synthesizable sequential fixed-point base-2 logarithm unit: the hardware DUT that the team's VPI `$log2` system function acts as the golden model for.
- Accepts an unsigned integer over a valid/ready handshake.
- Computes the integer part by leading-one detection and the fractional bits by iterative mantissa squaring, one fractional bit per clock.
- Returns an unsigned fixed-point result over a valid/ready handshake.

Parameters:
- WIDTH, 16, input argument width in bits (>= 2).
- FRAC, 8, number of fractional result bits (>= 1).
- MANT_W, FRAC+4, fractional bits of the internal mantissa. Mantissa is held as 1.MANT_W, i.e. MANT_W+1 bits.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  argument valid
- i_ready  out  1  unit can accept an argument
- i_arg  in  WIDTH  unsigned argument
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result
- o_log  out  $clog2(WIDTH)+FRAC  unsigned fixed point: integer part in the upper $clog2(WIDTH) bits, FRAC fraction bits below
- o_err  out  1  argument was zero (log undefined); qualified by o_valid

Behaviour:
- One clock domain. Reset is synchronous and active-high: ports `clock` and `reset`.
- Reset values:
  - state IDLE
  - i_ready=1, o_valid=0, o_log=0, o_err=0
  - internal mantissa and counter = 0
- Reset asserted in any state, including mid-ITER, aborts the operation. The next cycle shows IDLE values; the partial result is discarded.
- FSM states IDLE, NORM, ITER, DONE:
  - **IDLE**: i_ready=1. On i_valid&&i_ready at edge k, register i_arg and go to NORM.
  - **NORM** (cycle k+1):
    - If the argument is 0: o_log=0, o_err=1, go to DONE (o_valid from k+2).
    - Otherwise: integer part = msb index p (0..WIDTH-1). Mantissa = argument shifted left by WIDTH-1-p; the top MANT_W+1 bits are kept, zero-padded if WIDTH-1 < MANT_W. Mantissa MSB is 1. Counter = FRAC-1. Go to ITER.
  - **ITER** (FRAC cycles):
    - sq = m*m, 2*(MANT_W+1) bits, value in [1,4).
    - If sq >= 2: next fraction bit = 1 and m = sq[2*MANT_W+1 : MANT_W+1]. Otherwise: bit = 0 and m = sq[2*MANT_W : MANT_W].
    - Fraction bits are shifted in MSB-first.
    - When the counter reaches 0, go to DONE.
  - **DONE**: o_valid=1. o_log and o_err are stable while o_valid && !o_ready. On o_ready, go to IDLE and drop o_valid next cycle.
- i_ready=1 only in IDLE. There is no overlap of input acceptance with DONE.
- Latency for a nonzero argument: o_valid rises at edge k+FRAC+2. Throughput is one result per FRAC+3 cycles when o_ready is held high.
- Arithmetic is pure truncation with no rounding. The result never exceeds the true log2 and satisfies |o_log/2^FRAC - log2(arg)| < 2^-(FRAC-1) for every nonzero argument.
- Boundaries:
  - arg=1 gives exactly 0.
  - Powers of two give exact integers with zero fraction.
  - arg=2^WIDTH-1 gives integer WIDTH-1 with fraction all ones (within tolerance).
- Inputs are ignored outside IDLE. i_arg changing while i_ready=0 has no effect.

Decomposition:
- Package log2_pkg:
  - state enum (IDLE, NORM, ITER, DONE)
  - function fx2real(value, FRAC), used by benches to compare against the VPI `$log2`
- Sub-module log2_msb_detect: combinational priority encoder of WIDTH bits. It outputs the msb index ($clog2(WIDTH) bits) and a zero flag, and is instantiated once in NORM logic.

Test Plan (WIDTH=16, FRAC=8, o_log 12 bits, o_ready=1 unless stated):
- i_arg=1 -> o_log=0x000, o_err=0, o_valid at k+10.
- i_arg=256 -> o_log=0x800 (8.0), exact.
- i_arg=3 -> o_log=0x195 (405/256 ≈ 1.5820). Also compare with `$log2(3.0)` within 2^-7.
- i_arg=65535 -> o_log=0xFFF. i_arg=0 -> o_err=1, o_log=0, o_valid at k+2.
- Backpressure: hold o_ready=0 for 5 cycles after o_valid -> o_log stable, i_ready=0. The next i_valid is not accepted until the cycle after the o_ready handshake.
- Reset asserted at cycle k+5 during ITER -> next cycle i_ready=1, o_valid=0. A fresh i_arg=1024 then yields o_log=0xA00. A randomized sweep of 10k arguments versus the VPI `$log2` passes the tolerance check.
